pll_lock_detect: RTL and testbench



---
 rtl/pll_lock_detect.sv | 171 +++++++++++++++++
 tb/tb_pll_lock_detect.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_detect.sv
// pll_lock_detect
//   Qualifies the raw PLL lock flag into a clean lock for the core reset
//   generator. The raw flag is synchronized, must stay high for LOCK_CYCLES
//   before lock_o asserts, short drops while locked are filtered, and a real
//   loss forces a HOLDOFF period before requalification. Sticky loss status
//   and a saturating loss counter are kept for software.
//
// Ports
//   clk_i          reference clock (only clock)
//   rstn_i         asynchronous active-low reset
//   pll_lock_raw_i raw PLL lock flag, asynchronous to clk_i
//   testmode_i     forces lock_o high (FSM keeps running)
//   clr_lost_i     clears lock_lost_o and loss_cnt_o
//   lock_o         qualified lock
//   lock_lost_o    sticky: a qualified lock was lost
//   loss_cnt_o     saturating count of loss events
//   state_o        FSM state
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | waiting for synchronized lock to go high
// QUALIFY  | counting LOCK_CYCLES consecutive high cycles
// LOCKED   | lock_o high; filtering drops shorter than GLITCH_CYCLES
// HOLDOFF  | HOLDOFF_CYCLES cooldown after a real loss, input ignored

module pll_lock_detect #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_CYCLES    = 256,
  parameter int GLITCH_CYCLES  = 4,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int LOSS_W         = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              pll_lock_raw_i,
  input  logic              testmode_i,
  input  logic              clr_lost_i,
  output logic              lock_o,
  output logic              lock_lost_o,
  output logic [LOSS_W-1:0] loss_cnt_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_QUALIFY  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [1:0] ST_HOLDOFF  = 2'd3;

  localparam int CNT_W  = (LOCK_CYCLES    > 1) ? $clog2(LOCK_CYCLES)    : 1;
  localparam int GCNT_W = (GLITCH_CYCLES  > 1) ? $clog2(GLITCH_CYCLES)  : 1;
  localparam int HCNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GLITCH_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLDOFF_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              lock_q;
  logic              loss_evt;

  // Synchronizer: the only consumer of the raw input.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_raw_i};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    hcnt_d   = hcnt_q;
    loss_evt = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        cnt_d  = '0;
        gcnt_d = '0;
        if (lock_s) state_d = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!lock_s) begin
          state_d = ST_UNLOCKED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (lock_s) begin
          gcnt_d = '0;
        end else if (gcnt_q == GCNT_LAST) begin
          state_d  = ST_HOLDOFF;
          gcnt_d   = '0;
          hcnt_d   = '0;
          loss_evt = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GCNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        // Input deliberately ignored here so a chattering PLL cannot requalify early.
        if (hcnt_q == HCNT_LAST) begin
          state_d = ST_UNLOCKED;
          hcnt_d  = '0;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        cnt_d   = '0;
        gcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_UNLOCKED;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      hcnt_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      hcnt_q  <= hcnt_d;
      lock_q  <= (state_d == ST_LOCKED);
    end
  end

  // A loss in the same cycle as a clear wins: the new event is recorded as the first one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_lost_o <= 1'b0;
      loss_cnt_o  <= '0;
    end else if (loss_evt) begin
      lock_lost_o <= 1'b1;
      if (clr_lost_i) begin
        loss_cnt_o <= LOSS_W'(1);
      end else if (loss_cnt_o != {LOSS_W{1'b1}}) begin
        loss_cnt_o <= loss_cnt_o + LOSS_W'(1);
      end
    end else if (clr_lost_i) begin
      lock_lost_o <= 1'b0;
      loss_cnt_o  <= '0;
    end
  end

  assign lock_o  = lock_q | testmode_i;
  assign state_o = state_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Testbench for pll_lock_detect.
// Main instance uses default parameters and is checked against a run-length
// reference model. A second, fast-qualifying instance is used for the loss
// counter saturation scenario, checked against min(events, 255).
module tb_pll_lock_detect;

  localparam int SYNC    = 2;
  localparam int LOCKN   = 256;
  localparam int GLITCH  = 4;
  localparam int HOLDOFF = 16;

  logic       clk, rstn, raw, testmode, clr;
  logic       lock, lost;
  logic [7:0] cnt;
  logic [1:0] state;

  logic       raw_f, clr_f, tm_f;
  logic       lock_f, lost_f;
  logic [7:0] cnt_f;
  logic [1:0] state_f;

  int checks = 0;
  int errors = 0;

  pll_lock_detect dut (
    .clk_i(clk), .rstn_i(rstn), .pll_lock_raw_i(raw), .testmode_i(testmode),
    .clr_lost_i(clr), .lock_o(lock), .lock_lost_o(lost), .loss_cnt_o(cnt),
    .state_o(state)
  );

  pll_lock_detect #(.SYNC_STAGES(2), .LOCK_CYCLES(8), .GLITCH_CYCLES(2),
                    .HOLDOFF_CYCLES(4), .LOSS_W(8)) dut_fast (
    .clk_i(clk), .rstn_i(rstn), .pll_lock_raw_i(raw_f), .testmode_i(tm_f),
    .clr_lost_i(clr_f), .lock_o(lock_f), .lock_lost_o(lost_f), .loss_cnt_o(cnt_f),
    .state_o(state_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: phases described by run lengths of the synchronized input.
  int pipe[$];
  int m_state, h_run, l_run, hold_left, m_cnt;
  bit m_lost;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < SYNC; i++) pipe.push_back(0);
    m_state = 0; h_run = 0; l_run = 0; hold_left = 0; m_cnt = 0; m_lost = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit c);
    bit s, loss;
    s = (pipe.pop_front() != 0);
    pipe.push_back(int'(r));
    loss = 1'b0;
    if (m_state == 3) begin
      hold_left--;
      if (hold_left == 0) begin m_state = 0; h_run = 0; end
    end else if (m_state == 2) begin
      if (s) l_run = 0;
      else begin
        l_run++;
        if (l_run == GLITCH) begin
          loss = 1'b1; m_state = 3; hold_left = HOLDOFF; l_run = 0;
        end
      end
    end else begin
      h_run = s ? h_run + 1 : 0;
      m_state = (h_run == 0) ? 0 : (h_run <= LOCKN) ? 1 : 2;
      l_run = 0;
    end
    if (loss) begin
      m_lost = 1'b1;
      m_cnt  = c ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end else if (c) begin
      m_lost = 1'b0;
      m_cnt  = 0;
    end
  endtask

  function automatic bit m_lock();
    return (m_state == 2) || (testmode === 1'b1);
  endfunction

  task automatic step(input bit r, input bit c);
    raw = r; clr = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; raw = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; raw = 1'b0; clr = 1'b0; testmode = 1'b0;
    raw_f = 1'b0; clr_f = 1'b0; tm_f = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (lock !== 1'b0 || state !== 2'd0 || lost !== 1'b0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: lock=%b state=%0d lost=%b cnt=%0d, required 0/0/0/0", lock, state, lost, cnt);
    end
    checks++;
    if (cnt_f !== 8'd0 || lost_f !== 1'b0) begin
      errors++;
      $display("FAIL reset_fast: cnt=%0d lost=%b, required 0/0", cnt_f, lost_f);
    end
    rstn = 1'b1;
  endtask

  task automatic test_lock_latency();
    for (int e = 1; e <= 262; e++) begin
      step(1'b1, 1'b0);
      checks++;
      if (state !== 2'(m_state) || lock !== m_lock()) begin
        errors++;
        $display("FAIL latency_model e=%0d: state=%0d lock=%b, required %0d/%b", e, state, lock, m_state, m_lock());
      end
      if (e == 3) begin
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL latency_qualify: state=%0d, required 1", state); end
      end
      if (e == 258) begin
        checks++;
        if (lock !== 1'b0) begin errors++; $display("FAIL latency_258: lock=%b, required 0", lock); end
      end
      if (e == 259) begin
        checks++;
        if (lock !== 1'b1 || state !== 2'd2) begin
          errors++; $display("FAIL latency_259: lock=%b state=%0d, required 1/2", lock, state);
        end
      end
    end
    checks++;
    if (lost !== 1'b0 || cnt !== 8'd0) begin
      errors++; $display("FAIL latency_status: lost=%b cnt=%0d, required 0/0", lost, cnt);
    end
  endtask

  task automatic test_qualify_restart();
    do_reset();
    for (int e = 1; e <= 365; e++) begin
      step((e == 102) ? 1'b0 : 1'b1, 1'b0);
      checks++;
      if (state !== 2'(m_state) || lock !== m_lock()) begin
        errors++;
        $display("FAIL restart_model e=%0d: state=%0d lock=%b, required %0d/%b", e, state, lock, m_state, m_lock());
      end
      if (e == 104) begin
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL restart_drop: state=%0d, required 0", state); end
      end
      if (e == 360) begin
        checks++;
        if (lock !== 1'b0) begin errors++; $display("FAIL restart_early: lock=%b, required 0", lock); end
      end
      if (e == 361) begin
        checks++;
        if (lock !== 1'b1) begin errors++; $display("FAIL restart_rise: lock=%b, required 1", lock); end
      end
    end
  endtask

  task automatic test_glitch_and_loss();
    int len, gap, hold_seen;
    repeat (6) begin
      len = $urandom_range(GLITCH - 1, 1);
      gap = $urandom_range(5, 1);
      for (int i = 0; i < len + gap; i++) begin
        step((i < len) ? 1'b0 : 1'b1, 1'b0);
        checks++;
        if (lock !== 1'b1 || lost !== 1'b0 || state !== 2'(m_state) || lock !== m_lock()) begin
          errors++;
          $display("FAIL glitch_filter len=%0d: lock=%b lost=%b state=%0d, required 1/0/%0d", len, lock, lost, state, m_state);
        end
      end
    end
    repeat (4) step(1'b1, 1'b0);
    hold_seen = 0;
    for (int e = 1; e <= 30; e++) begin
      step((e <= GLITCH) ? 1'b0 : 1'b1, 1'b0);
      if (state === 2'd3) hold_seen++;
      checks++;
      if (state !== 2'(m_state) || lock !== m_lock() || lost !== m_lost || cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL loss_model e=%0d: state=%0d lock=%b lost=%b cnt=%0d, required %0d/%b/%b/%0d",
                 e, state, lock, lost, cnt, m_state, m_lock(), m_lost, m_cnt);
      end
      if (e == 5) begin
        checks++;
        if (lock !== 1'b1) begin errors++; $display("FAIL loss_before: lock=%b, required 1", lock); end
      end
      if (e == 6) begin
        checks++;
        if (lock !== 1'b0 || lost !== 1'b1 || cnt !== 8'd1 || state !== 2'd3) begin
          errors++;
          $display("FAIL loss_event: lock=%b lost=%b cnt=%0d state=%0d, required 0/1/1/3", lock, lost, cnt, state);
        end
      end
      if (e == 22) begin
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL holdoff_exit: state=%0d, required 0", state); end
      end
    end
    checks++;
    if (hold_seen != HOLDOFF) begin
      errors++; $display("FAIL holdoff_len: got %0d cycles, required %0d", hold_seen, HOLDOFF);
    end
    for (int e = 1; e <= 262; e++) begin
      step(1'b1, 1'b0);
      checks++;
      if (state !== 2'(m_state) || lock !== m_lock()) begin
        errors++;
        $display("FAIL requalify e=%0d: state=%0d lock=%b, required %0d/%b", e, state, lock, m_state, m_lock());
      end
    end
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL requalify_end: lock=%b, required 1", lock); end
  endtask

  task automatic test_clr_collision();
    for (int e = 1; e <= 285; e++) begin
      step((e <= GLITCH) ? 1'b0 : 1'b1, e == 6);
      checks++;
      if (state !== 2'(m_state) || lock !== m_lock() || lost !== m_lost || cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL collision_model e=%0d: state=%0d lost=%b cnt=%0d, required %0d/%b/%0d",
                 e, state, lost, cnt, m_state, m_lost, m_cnt);
      end
      if (e == 6) begin
        checks++;
        if (lost !== 1'b1 || cnt !== 8'd1) begin
          errors++; $display("FAIL collision_set_wins: lost=%b cnt=%0d, required 1/1", lost, cnt);
        end
      end
    end
    checks++;
    if (lock !== 1'b1 || state !== 2'd2) begin
      errors++; $display("FAIL collision_relock: lock=%b state=%0d, required 1/2", lock, state);
    end
  endtask

  task automatic test_async_reset();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (lock !== 1'b0 || state !== 2'd0 || lost !== 1'b0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: lock=%b state=%0d lost=%b cnt=%0d, required 0/0/0/0", lock, state, lost, cnt);
    end
    model_reset();
    raw = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_testmode();
    raw = 1'b0;
    testmode = 1'b1;
    #1;
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL testmode_comb: lock=%b, required 1", lock); end
    repeat (5) begin
      step(1'b0, 1'b0);
      checks++;
      if (lock !== 1'b1 || state !== 2'd0 || state !== 2'(m_state)) begin
        errors++; $display("FAIL testmode_fsm: lock=%b state=%0d, required 1/0", lock, state);
      end
    end
    testmode = 1'b0;
    #1;
    checks++;
    if (lock !== 1'b0) begin errors++; $display("FAIL testmode_off: lock=%b, required 0", lock); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    for (int i = 1; i <= 300; i++) begin
      raw_f = 1'b1;
      repeat (12 + $urandom_range(3, 0)) @(posedge clk);
      #1 raw_f = 1'b0;
      repeat (8 + $urandom_range(3, 0)) @(posedge clk);
      #1;
      exp_cnt = (i < 255) ? i : 255;
      checks++;
      if (cnt_f !== 8'(exp_cnt) || lost_f !== 1'b1 || state_f !== 2'd0 || lock_f !== 1'b0) begin
        errors++;
        $display("FAIL saturation i=%0d: cnt=%0d lost=%b state=%0d lock=%b, required %0d/1/0/0",
                 i, cnt_f, lost_f, state_f, lock_f, exp_cnt);
      end
    end
    clr_f = 1'b1;
    @(posedge clk);
    #1 clr_f = 1'b0;
    checks++;
    if (cnt_f !== 8'd0 || lost_f !== 1'b0) begin
      errors++; $display("FAIL saturation_clear: cnt=%0d lost=%b, required 0/0", cnt_f, lost_f);
    end
  endtask

  initial begin
    test_reset();
    test_lock_latency();
    test_qualify_restart();
    test_glitch_and_loss();
    test_clr_collision();
    test_async_reset();
    test_testmode();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
